// File: rtl/cipher_tx_pkg.sv
// Shared types and constants for the RC4 ciphertext serial framer.
// Optional parity bit is compiled in with CIPHER_TX_PARITY_EN.
package cipher_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Line levels: the channel rests high, a frame opens with a low start bit.
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

`ifdef CIPHER_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Line bits per frame for the default 7-bit character.
  localparam int N_DEFAULT  = 7;
  localparam int FRAME_BITS = N_DEFAULT + 2 + PARITY_BITS;

  // Line bits per frame for an arbitrary character width.
  function automatic int frame_bits(input int n);
    return n + 2 + PARITY_BITS;
  endfunction

endpackage

// File: rtl/cipher_fifo.sv
// Small synchronous FIFO buffering ciphertext characters ahead of the line.
// Head word is presented combinationally so the framer can load it on the pop edge.
module cipher_fifo
  import cipher_tx_pkg::*;
#(
  parameter int W     = 7,
  parameter int DEPTH = 8,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_next,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          push_ok;
  logic          pop_ok;

  // A push while full is dropped; a pop while empty is ignored.
  assign full       = (count_reg == CW'(DEPTH));
  assign empty      = (count_reg == '0);
  assign push_ok    = push && !full;
  assign pop_ok     = pop && !empty;
  assign count_next = count_reg + CW'(push_ok) - CW'(pop_ok);
  assign count      = count_reg;
  assign rdata      = mem[rd_ptr_reg];

  // Storage: written on accepted pushes only, never reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  // Pointers wrap naturally; occupancy tracks accepted pushes and pops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/cipher_tx_framer.sv
// Serial framer for RC4 ciphertext: FIFO-buffered characters are sent as
// start bit, N data bits LSB first, optional even parity, stop bit, with each
// line bit held for BIT_CYCLES clocks. Parity is enabled by CIPHER_TX_PARITY_EN.
module cipher_tx_framer
  import cipher_tx_pkg::*;
#(
  parameter int N          = 7,
  parameter int DEPTH      = 8,
  parameter int BIT_CYCLES = 4,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  data_in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          tx_bit,
  output logic          tx_busy,
  output logic [CW-1:0] fifo_count,
  output logic          overflow
);

  localparam int TW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

`ifdef CIPHER_TX_PARITY_EN
  localparam tx_state_t AFTER_DATA = PARITY;
`else
  localparam tx_state_t AFTER_DATA = STOP;
`endif

  tx_state_t     state_reg;
  tx_state_t     state_next;
  logic [TW-1:0] timer_reg;
  logic [IW-1:0] bit_idx_reg;
  logic [N-1:0]  sh_reg;
  logic          tx_bit_reg;
  logic          tx_bit_next;
  logic          in_ready_reg;
  logic          overflow_reg;
  logic          pop;
  logic          timer_tc;
  logic          last_bit;

  logic [N-1:0]  fifo_rdata;
  logic [CW-1:0] fifo_count_next;
  logic          fifo_full;
  logic          fifo_empty;

`ifdef CIPHER_TX_PARITY_EN
  logic          par_reg;
`endif

  cipher_fifo #(
    .W     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (in_valid),
    .wdata      (data_in),
    .pop        (pop),
    .rdata      (fifo_rdata),
    .count      (fifo_count),
    .count_next (fifo_count_next),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign timer_tc = (timer_reg == TW'(BIT_CYCLES - 1));
  assign last_bit = (bit_idx_reg == IW'(N - 1));

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: every non-idle state advances on the bit-timer terminal count.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (!fifo_empty) state_next = START;
      START:  if (timer_tc) state_next = DATA;
      DATA:   if (timer_tc && last_bit) state_next = AFTER_DATA;
`ifdef CIPHER_TX_PARITY_EN
      PARITY: if (timer_tc) state_next = STOP;
`endif
      STOP:   if (timer_tc) state_next = fifo_empty ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: line level for the current state and FIFO pop requests.
  // A pop at the end of STOP chains frames with no idle gap.
  always_comb begin
    pop         = 1'b0;
    tx_bit_next = LINE_IDLE;
    case (state_reg)
      IDLE: begin
        tx_bit_next = LINE_IDLE;
        pop         = !fifo_empty;
      end
      START:  tx_bit_next = LINE_START;
      DATA:   tx_bit_next = sh_reg[0];
`ifdef CIPHER_TX_PARITY_EN
      PARITY: tx_bit_next = par_reg;
`endif
      STOP: begin
        tx_bit_next = LINE_IDLE;
        pop         = timer_tc && !fifo_empty;
      end
      default: tx_bit_next = LINE_IDLE;
    endcase
  end

  assign tx_busy = (state_reg != IDLE);

  // Datapath: bit timer, data bit index, shift register and registered line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_reg   <= '0;
      bit_idx_reg <= '0;
      sh_reg      <= '0;
      tx_bit_reg  <= LINE_IDLE;
    end else begin
      tx_bit_reg <= tx_bit_next;
      if (state_reg == IDLE || timer_tc) begin
        timer_reg <= '0;
      end else begin
        timer_reg <= timer_reg + TW'(1);
      end
      if (pop) begin
        sh_reg <= fifo_rdata;
      end else if (state_reg == DATA && timer_tc) begin
        sh_reg <= sh_reg >> 1;
      end
      if (state_reg != DATA) begin
        bit_idx_reg <= '0;
      end else if (timer_tc) begin
        bit_idx_reg <= last_bit ? '0 : bit_idx_reg + IW'(1);
      end
    end
  end

`ifdef CIPHER_TX_PARITY_EN
  // Even parity of the character is captured as it leaves the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_reg <= 1'b0;
    end else if (pop) begin
      par_reg <= ^fifo_rdata;
    end
  end
`endif

  // Input handshake and sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready_reg <= 1'b1;
      overflow_reg <= 1'b0;
    end else begin
      in_ready_reg <= (fifo_count_next < CW'(DEPTH));
      if (in_valid && fifo_full) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign tx_bit   = tx_bit_reg;
  assign in_ready = in_ready_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_cipher_tx_framer.sv
// Directed bench for cipher_tx_framer: one instance at 4 clocks/bit, one at 1 clock/bit.
`timescale 1ns/1ps
module tb_cipher_tx_framer;

  localparam int N     = 7;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef CIPHER_TX_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [N-1:0]  data0, data1;
  logic          valid0, valid1;
  logic          ready0, ready1;
  logic          txb0, txb1;
  logic          busy0, busy1;
  logic          ovf0, ovf1;
  logic [CW-1:0] cnt0, cnt1;

  cipher_tx_framer #(.N(N), .DEPTH(DEPTH), .BIT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .data_in(data0), .in_valid(valid0), .in_ready(ready0),
    .tx_bit(txb0), .tx_busy(busy0), .fifo_count(cnt0), .overflow(ovf0)
  );

  cipher_tx_framer #(.N(N), .DEPTH(DEPTH), .BIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .data_in(data1), .in_valid(valid1), .in_ready(ready1),
    .tx_bit(txb1), .tx_busy(busy1), .fifo_count(cnt1), .overflow(ovf1)
  );

  // line[0] is the first bit on the wire: start, d0..d6, parity, stop.
  typedef struct {
    logic [N-1:0] data;
    logic [0:9]   line;
  } vec_t;

  vec_t tbl [6];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Samples one frame starting at the next falling edge.
  task automatic expect_frame(input int idx, input bit sel);
    int   bc;
    int   pos;
    logic exp_b;
    logic act_b;
    logic cur;
    bit   bad;
    bc = sel ? 1 : 4;
    for (int j = 0; j < NB; j++) begin
      pos   = (NB == 10) ? j : ((j < 8) ? j : 9);
      exp_b = tbl[idx].line[pos];
      bad   = 1'b0;
      act_b = exp_b;
      for (int c = 0; c < bc; c++) begin
        @(negedge clk);
        cur = sel ? txb1 : txb0;
        if (cur !== exp_b) begin
          bad   = 1'b1;
          act_b = cur;
        end
      end
      tests++;
      if (bad) begin
        fails++;
        $display("FAIL frame_%02h_bit%0d dut%0d: tx_bit=%b expected %b", tbl[idx].data, j, sel, act_b, exp_b);
      end
    end
    $display("[TB] frame %02h on dut%0d: %0d bits x %0d clocks sampled", tbl[idx].data, sel, NB, bc);
  endtask

  task automatic push(input bit sel, input logic [N-1:0] d);
    @(negedge clk);
    if (sel) begin data1 = d; valid1 = 1'b1; end
    else     begin data0 = d; valid0 = 1'b1; end
    @(negedge clk);
    valid0 = 1'b0;
    valid1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;
    tbl[0] = '{data: 7'h55, line: 10'b0101010101};
    tbl[1] = '{data: 7'h01, line: 10'b0100000011};
    tbl[2] = '{data: 7'h7F, line: 10'b0111111111};
    tbl[3] = '{data: 7'h2A, line: 10'b0010101011};
    tbl[4] = '{data: 7'h07, line: 10'b0111000011};
    tbl[5] = '{data: 7'h00, line: 10'b0000000001};

    rst = 1'b0; valid0 = 1'b0; valid1 = 1'b0; data0 = '0; data1 = '0;
    repeat (3) @(negedge clk);
    check("reset tx_bit", txb0, 1);
    check("reset tx_busy", busy0, 0);
    check("reset in_ready", ready0, 1);
    check("reset fifo_count", cnt0, 0);
    check("reset overflow", ovf0, 0);
    rst = 1'b1;
    @(negedge clk);

    // Single frames through both instances.
    for (int i = 0; i < 6; i++) begin
      push(0, tbl[i].data);
      check("dut0 count after push", cnt0, 1);
      @(negedge clk);
      check("dut0 busy at pop", busy0, 1);
      check("dut0 line high before start", txb0, 1);
      expect_frame(i, 0);
      check("dut0 busy after frame", busy0, 0);
      check("dut0 count after frame", cnt0, 0);
    end
    for (int i = 0; i < 6; i++) begin
      push(1, tbl[i].data);
      @(negedge clk);
      check("dut1 busy at pop", busy1, 1);
      expect_frame(i, 1);
      check("dut1 busy after frame", busy1, 0);
      check("dut1 line idle after frame", txb1, 1);
    end

    // Back-to-back pushes: the second push coincides with the first pop, so count holds at 1.
    @(negedge clk);
    data0 = 7'h01; valid0 = 1'b1;
    @(negedge clk);
    check("b2b count after first push", cnt0, 1);
    data0 = 7'h7F;
    @(negedge clk);
    valid0 = 1'b0;
    check("b2b count after second push", cnt0, 1);
    expect_frame(1, 0);
    check("b2b no gap busy", busy0, 1);
    check("b2b count after second pop", cnt0, 0);
    expect_frame(2, 0);
    check("b2b busy after both", busy0, 0);

    @(negedge clk);
    data1 = 7'h55; valid1 = 1'b1;
    @(negedge clk);
    data1 = 7'h00;
    @(negedge clk);
    valid1 = 1'b0;
    expect_frame(0, 1);
    check("b2b dut1 no gap busy", busy1, 1);
    expect_frame(5, 1);
    check("b2b dut1 busy after both", busy1, 0);

    // Overflow: 10 consecutive pushes while the line drains.
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          if (k == 9) begin
            check("ovf not yet set", ovf0, 0);
            check("ovf in_ready low when full", ready0, 0);
            check("ovf count full", cnt0, DEPTH);
          end
          data0  = (k < 9) ? tbl[k % 5].data : tbl[5].data;
          valid0 = 1'b1;
        end
        @(negedge clk);
        valid0 = 1'b0;
        check("ovf set on dropped write", ovf0, 1);
        check("ovf count stays full", cnt0, DEPTH);
        check("ovf in_ready still low", ready0, 0);
      end
      begin
        repeat (3) @(negedge clk);
        for (int k = 0; k < 9; k++) expect_frame(k % 5, 0);
      end
    join
    check("ovf drained busy", busy0, 0);
    check("ovf drained count", cnt0, 0);
    check("ovf drained in_ready", ready0, 1);
    check("ovf sticky", ovf0, 1);
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (txb0 !== 1'b1 || busy0 !== 1'b0) bad = 1'b1;
    end
    check("dropped word never sent", bad, 0);
    check("ovf still sticky", ovf0, 1);

    // Reset during DATA bit 3 of 0x2A with another word queued.
    push(0, 7'h2A);
    push(0, 7'h00);
    repeat (17) @(negedge clk);
    check("mid-frame data bit3", txb0, 1);
    check("mid-frame busy", busy0, 1);
    check("mid-frame queued count", cnt0, 1);
    #2;
    rst = 1'b0;
    #1;
    check("async reset tx_bit", txb0, 1);
    check("async reset busy", busy0, 0);
    check("async reset count", cnt0, 0);
    check("async reset overflow", ovf0, 0);
    check("async reset in_ready", ready0, 1);
    @(negedge clk);
    rst = 1'b1;
    bad = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (txb0 !== 1'b1 || busy0 !== 1'b0) bad = 1'b1;
    end
    check("line quiet after reset", bad, 0);
    check("count zero after reset", cnt0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
